// File: rtl/turing_machine.sv
// Programmable single-tape binary Turing machine driven by two push buttons.
// The user first enters a rule table, then a head position and initial tape
// contents, and finally single-steps the machine until it halts.
module turing_machine #(
    parameter int W        = 6,
    parameter int TAPE_LEN = 64
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [W-1:0]  input_data,
    input  logic          Next,
    input  logic          Done,
    output logic [10:0]   display_out,
    output logic [3:0]    currState,
    output logic          display_in,
    output logic          tape_reg_out,
    output logic          data_reg_out,
    output logic [W-1:0]  next_state_out,
    output logic [W-1:0]  tape_addr_out,
    output logic          Compute_done
);

    localparam int RULES = 2 * (2 ** W);
    localparam int RW    = W + 1;

    typedef enum logic [3:0] {
        PROG_S    = 4'd0,
        PROG_WR   = 4'd1,
        PROG_MV   = 4'd2,
        PROG_NX   = 4'd3,
        TAPE_HEAD = 4'd4,
        TAPE_DATA = 4'd5,
        RUN       = 4'd6,
        HALT      = 4'd7
    } ctrl_t;

    ctrl_t                state_reg, state_next;
    logic                 next_q_reg, done_q_reg;
    logic [W-1:0]         s_reg;
    logic [W-1:0]         tm_state_reg;
    logic [W-1:0]         head_reg;
    logic [W-1:0]         tape_off_reg;
    logic [RW-1:0]        rule_idx_reg;
    logic [TAPE_LEN-1:0]  tape_reg;
    logic                 rule_wr_reg [RULES];
    logic [1:0]           rule_mv_reg [RULES];
    logic [W-1:0]         rule_nx_reg [RULES];

    logic                 next_ev, done_ev, in_input, done_act, next_act;
    logic                 run_ok, rule_room, sym;
    logic [RW-1:0]        sel_idx;
    logic                 sel_wr;
    logic [1:0]           sel_mv;
    logic [W-1:0]         sel_nx;
    logic [W-1:0]         head_step;
    logic                 rule_we_wr, rule_we_mv, rule_we_nx;
    logic                 tape_we, tape_wdata;
    logic [W-1:0]         tape_waddr;
    logic [10:0]          win;

    // Button edges; Done wins over Next only in phases where Done means something
    assign next_ev   = Next & ~next_q_reg;
    assign done_ev   = Done & ~done_q_reg;
    assign in_input  = (state_reg != RUN) && (state_reg != HALT);
    assign done_act  = done_ev && in_input;
    assign next_act  = next_ev && !done_act;

    // Rule currently addressed by (TM state, symbol under head)
    assign run_ok    = tm_state_reg < s_reg;
    assign rule_room = rule_idx_reg < {s_reg, 1'b0};
    assign sym       = tape_reg[head_reg];
    assign sel_idx   = {tm_state_reg, sym};
    assign sel_wr    = rule_wr_reg[sel_idx];
    assign sel_mv    = rule_mv_reg[sel_idx];
    assign sel_nx    = rule_nx_reg[sel_idx];

    // Head movement: 0 left, 1 right, anything else stays; W-bit math wraps
    always_comb begin
        head_step = head_reg;
        case (sel_mv)
            2'd0:    head_step = head_reg - W'(1);
            2'd1:    head_step = head_reg + W'(1);
            default: head_step = head_reg;
        endcase
    end

    // Write strobes for the rule table and the tape
    always_comb begin
        rule_we_wr = next_act && (state_reg == PROG_WR) && rule_room;
        rule_we_mv = next_act && (state_reg == PROG_MV) && rule_room;
        rule_we_nx = next_act && (state_reg == PROG_NX) && rule_room;
        tape_we    = 1'b0;
        tape_waddr = head_reg;
        tape_wdata = 1'b0;
        if (next_act && (state_reg == TAPE_DATA)) begin
            tape_we    = 1'b1;
            tape_waddr = head_reg + tape_off_reg;
            tape_wdata = input_data[0];
        end else if (next_act && (state_reg == RUN) && run_ok) begin
            tape_we    = 1'b1;
            tape_waddr = head_reg;
            tape_wdata = sel_wr;
        end
    end

    // Controller state register
    always_ff @(posedge clock) begin
        if (!reset) state_reg <= PROG_S;
        else        state_reg <= state_next;
    end

    // Controller next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            PROG_S:    if (done_act) state_next = TAPE_HEAD;
                       else if (next_act) state_next = PROG_WR;
            PROG_WR:   if (done_act) state_next = TAPE_HEAD;
                       else if (next_act) state_next = PROG_MV;
            PROG_MV:   if (done_act) state_next = TAPE_HEAD;
                       else if (next_act) state_next = PROG_NX;
            PROG_NX:   if (done_act) state_next = TAPE_HEAD;
                       else if (next_act) state_next = PROG_WR;
            TAPE_HEAD: if (done_act) state_next = RUN;
                       else if (next_act) state_next = TAPE_DATA;
            TAPE_DATA: if (done_act) state_next = RUN;
            RUN:       if (!run_ok) state_next = HALT;
                       else if (next_act && (sel_nx >= s_reg)) state_next = HALT;
            HALT:      state_next = HALT;
            default:   state_next = PROG_S;
        endcase
    end

    // Edge samplers, state count, TM registers and entry counters
    always_ff @(posedge clock) begin
        if (!reset) begin
            next_q_reg   <= 1'b0;
            done_q_reg   <= 1'b0;
            s_reg        <= '0;
            tm_state_reg <= '0;
            head_reg     <= W'(TAPE_LEN / 2);
            tape_off_reg <= '0;
            rule_idx_reg <= '0;
        end else begin
            next_q_reg <= Next;
            done_q_reg <= Done;
            if (next_act) begin
                case (state_reg)
                    PROG_S:    s_reg <= input_data;
                    PROG_NX:   if (rule_room) rule_idx_reg <= rule_idx_reg + RW'(1);
                    TAPE_HEAD: head_reg <= input_data;
                    TAPE_DATA: tape_off_reg <= tape_off_reg + W'(1);
                    RUN: if (run_ok) begin
                        tm_state_reg <= sel_nx;
                        head_reg     <= head_step;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Rule table; unprogrammed entries write 0, stay, and jump to all-ones
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < RULES; i++) begin
                rule_wr_reg[i] <= 1'b0;
                rule_mv_reg[i] <= 2'd2;
                rule_nx_reg[i] <= '1;
            end
        end else begin
            if (rule_we_wr) rule_wr_reg[rule_idx_reg] <= input_data[0];
            if (rule_we_mv) rule_mv_reg[rule_idx_reg] <= input_data[1:0];
            if (rule_we_nx) rule_nx_reg[rule_idx_reg] <= input_data;
        end
    end

    // Tape storage
    always_ff @(posedge clock) begin
        if (!reset)       tape_reg <= '0;
        else if (tape_we) tape_reg[tape_waddr] <= tape_wdata;
    end

    // 11-cell window centred on the head; bit 5 is the cell under the head
    for (genvar gi = 0; gi < 11; gi++) begin : g_win
        localparam logic [W-1:0] OFS = W'(TAPE_LEN + gi - 5);
        assign win[10-gi] = tape_reg[head_reg + OFS];
    end

    assign display_in     = in_input;
    assign display_out    = in_input ? {{(11-W){1'b0}}, input_data} : win;
    assign currState      = state_reg;
    assign tape_reg_out   = sym;
    assign data_reg_out   = sel_wr;
    assign next_state_out = tm_state_reg;
    assign tape_addr_out  = head_reg;
    assign Compute_done   = (state_reg == HALT);

endmodule

// File: tb/tb_turing_machine.sv
// Directed bench for turing_machine: expectations are queued as stimulus is
// applied and drained against the outputs once they have settled.
module tb_turing_machine;
    localparam int W = 6;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]  input_data = '0;
    logic          Next = 1'b0;
    logic          Done = 1'b0;
    logic [10:0]   display_out;
    logic [3:0]    currState;
    logic          display_in;
    logic          tape_reg_out;
    logic          data_reg_out;
    logic [W-1:0]  next_state_out;
    logic [W-1:0]  tape_addr_out;
    logic          Compute_done;

    turing_machine #(.W(W), .TAPE_LEN(64)) dut (
        .clock(clock), .reset(reset), .input_data(input_data),
        .Next(Next), .Done(Done), .display_out(display_out),
        .currState(currState), .display_in(display_in),
        .tape_reg_out(tape_reg_out), .data_reg_out(data_reg_out),
        .next_state_out(next_state_out), .tape_addr_out(tape_addr_out),
        .Compute_done(Compute_done)
    );

    always #5 clock = ~clock;

    localparam int S_CS = 0, S_ADDR = 1, S_ST = 2, S_DONE = 3,
                   S_DIN = 4, S_DOUT = 5, S_TAPE = 6, S_DATA = 7;

    int checks = 0;
    int failures = 0;
    string       tag_q[$];
    int          sig_q[$];
    logic [31:0] exp_q[$];

    int words[18] = '{1,1,2, 1,0,3, 1,0,1, 1,1,2, 1,0,2, 1,2,3};

    function automatic logic [31:0] observe(int sig);
        case (sig)
            S_CS:    return 32'(currState);
            S_ADDR:  return 32'(tape_addr_out);
            S_ST:    return 32'(next_state_out);
            S_DONE:  return 32'(Compute_done);
            S_DIN:   return 32'(display_in);
            S_DOUT:  return 32'(display_out);
            S_TAPE:  return 32'(tape_reg_out);
            S_DATA:  return 32'(data_reg_out);
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic expect_sig(input string tag, input int sig, input logic [31:0] v);
        tag_q.push_back(tag);
        sig_q.push_back(sig);
        exp_q.push_back(v);
    endtask

    task automatic expect_core(input string tag, input int cs, input int addr,
                               input int st, input int cdone);
        expect_sig({tag, ".currState"}, S_CS, 32'(cs));
        expect_sig({tag, ".tape_addr"}, S_ADDR, 32'(addr));
        expect_sig({tag, ".tm_state"}, S_ST, 32'(st));
        expect_sig({tag, ".Compute_done"}, S_DONE, 32'(cdone));
    endtask

    task automatic drain();
        string t;
        int s;
        logic [31:0] e, o;
        while (exp_q.size() > 0) begin
            t = tag_q.pop_front();
            s = sig_q.pop_front();
            e = exp_q.pop_front();
            o = observe(s);
            checks++;
            assert (o === e) else begin
                failures++;
                $error("FAIL %s observed=0x%0h expected=0x%0h", t, o, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic press_next(input int d);
        input_data = W'(d);
        Next = 1'b1;
        tick();
        Next = 1'b0;
        tick();
    endtask

    task automatic press_done();
        Done = 1'b1;
        tick();
        Done = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        Next = 1'b0;
        Done = 1'b0;
        input_data = '0;
        tick();
        reset = 1'b1;
    endtask

    task automatic program_t3();
        press_next(3);
        for (int i = 0; i < 18; i++) press_next(words[i]);
        press_done();
        press_done();
    endtask

    initial begin
        // T1: reset state
        do_reset();
        expect_core("T1", 0, 32, 0, 0);
        expect_sig("T1.display_in", S_DIN, 1);
        expect_sig("T1.display_out", S_DOUT, 0);
        drain();
        $display("txn T1 reset: cs=%0d addr=%0d", currState, tape_addr_out);

        // T2: Next held for 6 cycles counts once
        input_data = 6'd3;
        Next = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            expect_sig("T2.held_cs", S_CS, 1);
            drain();
        end
        Next = 1'b0;
        tick();
        expect_sig("T2.cs", S_CS, 1);
        expect_sig("T2.display_out", S_DOUT, 3);
        drain();
        $display("txn T2 debounce: cs=%0d disp=%0d", currState, display_out);

        // T3: rule entry, back to PROG_WR after six full rules
        for (int i = 0; i < 18; i++) press_next(words[i]);
        expect_sig("T3.after_rules_cs", S_CS, 1);
        drain();
        press_done();
        input_data = 6'd9;
        #1;
        expect_core("T3.head", 4, 32, 0, 0);
        expect_sig("T3.echo", S_DOUT, 9);
        drain();
        press_done();
        expect_core("T3.run", 6, 32, 0, 0);
        expect_sig("T3.display_in", S_DIN, 0);
        expect_sig("T3.display_out", S_DOUT, 0);
        expect_sig("T3.data_reg", S_DATA, 1);
        expect_sig("T3.tape_reg", S_TAPE, 0);
        drain();
        $display("txn T3 program: cs=%0d", currState);

        // T4: three steps to halt
        press_next(0);
        expect_core("T4.step1", 6, 33, 2, 0);
        drain();
        press_next(0);
        expect_core("T4.step2", 6, 32, 2, 0);
        expect_sig("T4.step2_tape", S_TAPE, 1);
        drain();
        press_next(0);
        expect_core("T4.step3", 7, 32, 3, 1);
        expect_sig("T4.window", S_DOUT, 11'b00000110000);
        drain();
        press_next(0);
        press_done();
        expect_core("T4.frozen", 7, 32, 3, 1);
        expect_sig("T4.frozen_window", S_DOUT, 11'b00000110000);
        drain();
        $display("txn T4 run: cs=%0d addr=%0d st=%0d disp=%b", currState,
                 tape_addr_out, next_state_out, display_out);

        // T6: reset in the middle of a run clears everything
        do_reset();
        program_t3();
        press_next(0);
        expect_core("T6.pre", 6, 33, 2, 0);
        drain();
        do_reset();
        expect_core("T6.reset", 0, 32, 0, 0);
        expect_sig("T6.display_in", S_DIN, 1);
        drain();
        press_next(1);
        press_done();
        // Done and Next together: Done wins, head stays put
        input_data = 6'd10;
        Next = 1'b1;
        Done = 1'b1;
        tick();
        Next = 1'b0;
        Done = 1'b0;
        tick();
        expect_core("T6.priority", 6, 32, 0, 0);
        expect_sig("T6.rule_cleared", S_DATA, 0);
        expect_sig("T6.tape_cleared", S_DOUT, 0);
        drain();
        press_next(0);
        expect_core("T6.unprog_halt", 7, 32, 63, 1);
        drain();
        $display("txn T6 reset-mid-run: cs=%0d st=%0d", currState, next_state_out);

        // T5: wrap from cell 63 to 0
        do_reset();
        press_next(1);
        press_next(1);
        press_next(1);
        press_next(1);
        press_done();
        press_next(63);
        expect_core("T5.head", 5, 63, 0, 0);
        drain();
        press_done();
        press_next(0);
        expect_core("T5.wrap", 7, 0, 1, 1);
        expect_sig("T5.window", S_DOUT, 11'b00001000000);
        expect_sig("T5.tape_reg", S_TAPE, 0);
        drain();
        $display("txn T5 wrap: addr=%0d disp=%b", tape_addr_out, display_out);

        // T7: tape entry wraps, S=0 halts on entering RUN
        do_reset();
        press_next(0);
        press_done();
        press_next(62);
        press_next(1);
        press_next(0);
        press_next(1);
        expect_core("T7.entry", 5, 62, 0, 0);
        drain();
        press_done();
        for (int i = 0; i < 10 && currState != 4'd7; i++) tick();
        expect_core("T7.halt", 7, 62, 0, 1);
        expect_sig("T7.window", S_DOUT, 11'b00000101000);
        drain();
        $display("txn T7 s0: cs=%0d disp=%b", currState, display_out);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
